// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source two-entry result buffers feeding a
// round-robin grant that drives one registered broadcast per cycle.
module cdb_arbiter #(
   parameter int                 NUM_SRC     = 4,
   parameter int                 TAG_W       = 4,
   parameter logic [TAG_W-1:0]   INVALID_TAG = '1,
   parameter int                 DEPTH       = 2
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic [NUM_SRC-1:0]       src_valid,
   output logic [NUM_SRC-1:0]       src_ready,
   input  logic [NUM_SRC*TAG_W-1:0] src_tag,
   input  logic [NUM_SRC*32-1:0]    src_data,
   output logic                     cdb_valid,
   output logic [TAG_W-1:0]         cdb_tag,
   output logic [31:0]              cdb_data
);

   localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int EW = TAG_W + 32;

   logic [1:0]         count  [NUM_SRC];
   logic [NUM_SRC-1:0] rd_ptr;
   logic [NUM_SRC-1:0] wr_ptr;
   logic [EW-1:0]      mem    [NUM_SRC][DEPTH];
   logic [PW-1:0]      rr_ptr;

   logic [NUM_SRC-1:0] nonempty;
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic               found;
   logic [PW-1:0]      gnt;
   logic [PW-1:0]      rr_next;
   logic [EW-1:0]      head;

   // Ready depends only on registered counts, never on this cycle's inputs.
   always_comb begin
      src_ready = '0;
      nonempty  = '0;
      push      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_ready[i] = (count[i] < 2'(DEPTH));
         nonempty[i]  = (count[i] != 2'd0);
         push[i]      = src_valid[i] & src_ready[i] & ~flush;
      end
   end

   always_comb begin : arb
      int idx;
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_SRC;
         if (!found && nonempty[idx]) begin
            found = 1'b1;
            gnt   = PW'(idx);
         end
      end
      rr_next = PW'((int'(gnt) + 1) % NUM_SRC);
   end

   always_comb begin
      pop = '0;
      if (found && !flush)
         pop[gnt] = 1'b1;
   end

   assign head = mem[gnt][rd_ptr[gnt]];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_SRC; i++)
            count[i] <= 2'd0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= INVALID_TAG;
         cdb_data  <= '0;
      end else if (flush) begin
         for (int i = 0; i < NUM_SRC; i++)
            count[i] <= 2'd0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         rr_ptr    <= '0;
         cdb_valid <= 1'b0;
         cdb_tag   <= INVALID_TAG;
         cdb_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            count[i] <= count[i] + 2'(push[i]) - 2'(pop[i]);
            // One-bit pointers wrap naturally over the two entries.
            if (push[i])
               wr_ptr[i] <= ~wr_ptr[i];
            if (pop[i])
               rd_ptr[i] <= ~rd_ptr[i];
         end
         if (found) begin
            cdb_valid <= 1'b1;
            cdb_tag   <= head[EW-1 -: TAG_W];
            cdb_data  <= head[31:0];
            rr_ptr    <= rr_next;
         end else begin
            cdb_valid <= 1'b0;
            cdb_tag   <= INVALID_TAG;
            cdb_data  <= '0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      for (int i = 0; i < NUM_SRC; i++)
         if (push[i])
            mem[i][wr_ptr[i]] <= {src_tag[i*TAG_W +: TAG_W],
                                  src_data[i*32 +: 32]};
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, corner sequences and
// random traffic against a queue-based reference model.
module tb_cdb_arbiter;

   logic         CLK;
   logic         RST;
   logic         flush;
   logic [3:0]   src_valid;
   logic [3:0]   src_ready;
   logic [15:0]  src_tag;
   logic [127:0] src_data;
   logic         cdb_valid;
   logic [3:0]   cdb_tag;
   logic [31:0]  cdb_data;

   cdb_arbiter dut (
      .CLK       (CLK),
      .RST       (RST),
      .flush     (flush),
      .src_valid (src_valid),
      .src_ready (src_ready),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         f;
      logic [3:0]   v;
      logic [15:0]  t;
      logic [127:0] d;
      logic         ev;
      logic [3:0]   et;
      logic [31:0]  ed;
      logic [3:0]   er;
   } vec_t;

   vec_t tbl[10];

   // Reference model: one queue per source plus a round-robin start index.
   logic [35:0] mq[4][$];
   int          mrr;
   logic        mv;
   logic [3:0]  mt;
   logic [31:0] md;

   function automatic vec_t mk(logic f, logic [3:0] v, logic [15:0] t,
                               logic [127:0] d, logic ev, logic [3:0] et,
                               logic [31:0] ed, logic [3:0] er);
      vec_t r;
      r.f = f; r.v = v; r.t = t; r.d = d;
      r.ev = ev; r.et = et; r.ed = ed; r.er = er;
      return r;
   endfunction

   function automatic void m_reset();
      for (int i = 0; i < 4; i++)
         mq[i].delete();
      mrr = 0;
      mv  = 1'b0;
      mt  = 4'hF;
      md  = 32'h0;
   endfunction

   function automatic logic [3:0] m_ready();
      logic [3:0] r;
      for (int i = 0; i < 4; i++)
         r[i] = (mq[i].size() < 2);
      return r;
   endfunction

   function automatic void m_edge();
      logic [3:0]  rdy;
      int          g;
      int          s;
      logic [35:0] e;
      if (flush) begin
         m_reset();
         return;
      end
      rdy = m_ready();
      g = -1;
      for (int k = 0; k < 4; k++) begin
         s = (mrr + k) % 4;
         if (g < 0 && mq[s].size() != 0)
            g = s;
      end
      if (g >= 0) begin
         e   = mq[g].pop_front();
         mv  = 1'b1;
         mt  = e[35:32];
         md  = e[31:0];
         mrr = (g + 1) % 4;
      end else begin
         mv = 1'b0;
         mt = 4'hF;
         md = 32'h0;
      end
      for (int i = 0; i < 4; i++)
         if (src_valid[i] && rdy[i])
            mq[i].push_back({src_tag[i*4 +: 4], src_data[i*32 +: 32]});
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_model(string nm);
      chk({nm, ".valid"}, 32'(cdb_valid), 32'(mv));
      chk({nm, ".tag"},   32'(cdb_tag),   32'(mt));
      chk({nm, ".data"},  cdb_data,       md);
      chk({nm, ".ready"}, 32'(src_ready), 32'(m_ready()));
   endtask

   task automatic drive(logic f, logic [3:0] v, logic [15:0] t,
                        logic [127:0] d);
      flush     = f;
      src_valid = v;
      src_tag   = t;
      src_data  = d;
   endtask

   task automatic cyc();
      @(posedge CLK);
      m_edge();
      #1;
   endtask

   logic [3:0] seen[$];

   initial begin
      RST = 1'b1;
      drive(1'b0, 4'h0, 16'h0, 128'h0);
      m_reset();
      #2;
      chk("rst.valid", 32'(cdb_valid), 32'h0);
      chk("rst.tag",   32'(cdb_tag),   32'hF);
      chk("rst.data",  cdb_data,       32'h0);
      chk("rst.ready", 32'(src_ready), 32'hF);
      @(posedge CLK);
      @(posedge CLK);
      #2 RST = 1'b0;

      // Single result, flush to rewind rr_ptr, then four-way contention.
      tbl[0] = mk(0, 4'b0010, 16'h0050, {64'h0, 32'hDEADBEEF, 32'h0},
                  0, 4'hF, 32'h0, 4'hF);
      tbl[1] = mk(0, 4'b0000, 16'h0, 128'h0, 1, 4'h5, 32'hDEADBEEF, 4'hF);
      tbl[2] = mk(0, 4'b0000, 16'h0, 128'h0, 0, 4'hF, 32'h0, 4'hF);
      tbl[3] = mk(1, 4'b0000, 16'h0, 128'h0, 0, 4'hF, 32'h0, 4'hF);
      tbl[4] = mk(0, 4'b1111, 16'h4321,
                  {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0, 4'hF, 32'h0, 4'hF);
      tbl[5] = mk(0, 4'b0000, 16'h0, 128'h0, 1, 4'h1, 32'hA0, 4'hF);
      tbl[6] = mk(0, 4'b0000, 16'h0, 128'h0, 1, 4'h2, 32'hA1, 4'hF);
      tbl[7] = mk(0, 4'b0000, 16'h0, 128'h0, 1, 4'h3, 32'hA2, 4'hF);
      tbl[8] = mk(0, 4'b0000, 16'h0, 128'h0, 1, 4'h4, 32'hA3, 4'hF);
      tbl[9] = mk(0, 4'b0000, 16'h0, 128'h0, 0, 4'hF, 32'h0, 4'hF);

      for (int r = 0; r < 10; r++) begin
         drive(tbl[r].f, tbl[r].v, tbl[r].t, tbl[r].d);
         cyc();
         chk($sformatf("vec%0d.valid", r), 32'(cdb_valid), 32'(tbl[r].ev));
         chk($sformatf("vec%0d.tag", r),   32'(cdb_tag),   32'(tbl[r].et));
         chk($sformatf("vec%0d.data", r),  cdb_data,       tbl[r].ed);
         chk($sformatf("vec%0d.ready", r), 32'(src_ready), 32'(tbl[r].er));
      end

      // Backpressure: source 0 fills while others win, third result held.
      drive(1, 4'b0000, 16'h0, 128'h0); cyc(); chk_model("bp.fl");
      seen.delete();
      drive(0, 4'b1110, 16'h3210, {32'h33, 32'h22, 32'h11, 32'h0});
      cyc(); chk_model("bp.e1");
      drive(0, 4'b1111, 16'h3218, {32'h34, 32'h23, 32'h12, 32'h80});
      cyc(); chk_model("bp.e2");
      drive(0, 4'b0001, 16'h0009, {96'h0, 32'h90});
      cyc(); chk_model("bp.e3");
      chk("bp.ready0_full", 32'(src_ready[0]), 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 4'b0001, 16'h000A, {96'h0, 32'hA0});
         cyc(); chk_model($sformatf("bp.h%0d", i));
         if (cdb_valid && cdb_tag >= 4'h8) seen.push_back(cdb_tag);
      end
      drive(0, 4'b0000, 16'h0, 128'h0);
      for (int i = 0; i < 8; i++) begin
         cyc(); chk_model($sformatf("bp.d%0d", i));
         if (cdb_valid && cdb_tag >= 4'h8) seen.push_back(cdb_tag);
      end
      chk("bp.count", 32'(seen.size()), 32'd3);
      for (int i = 0; i < 3 && i < seen.size(); i++)
         chk($sformatf("bp.order%0d", i), 32'(seen[i]), 32'(8 + i));

      // Fairness: sources 0 and 3 always requesting.
      drive(1, 4'b0000, 16'h0, 128'h0); cyc(); chk_model("fa.fl");
      seen.delete();
      drive(0, 4'b1001, 16'hB00A, {32'hB, 64'h0, 32'hA});
      for (int i = 0; i < 9; i++) begin
         cyc(); chk_model($sformatf("fa.c%0d", i));
         if (cdb_valid) seen.push_back(cdb_tag);
      end
      chk("fa.count", 32'(seen.size()), 32'd8);
      for (int i = 0; i < 8 && i < seen.size(); i++)
         chk($sformatf("fa.g%0d", i), 32'(seen[i]),
             (i % 2 == 0) ? 32'hA : 32'hB);

      // Flush with buffers busy and a broadcast on the bus.
      drive(0, 4'b0011, 16'h00DC, {64'h0, 32'hD, 32'hC});
      for (int i = 0; i < 3; i++) begin
         cyc(); chk_model($sformatf("fl.p%0d", i));
      end
      chk("fl.pre_valid", 32'(cdb_valid), 32'h1);
      flush = 1'b1;
      cyc(); chk_model("fl.f");
      chk("fl.valid", 32'(cdb_valid), 32'h0);
      chk("fl.ready", 32'(src_ready), 32'hF);
      drive(0, 4'b0000, 16'h0, 128'h0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("fl.idle%0d", i), 32'(cdb_valid), 32'h0);
      end

      // Asynchronous reset between edges with results pending.
      drive(0, 4'b1111, 16'h4321, {32'h4, 32'h3, 32'h2, 32'h1});
      cyc(); cyc();
      drive(0, 4'b0000, 16'h0, 128'h0);
      cyc();
      #2 RST = 1'b1;
      #1;
      chk("ar.valid", 32'(cdb_valid), 32'h0);
      chk("ar.tag",   32'(cdb_tag),   32'hF);
      chk("ar.data",  cdb_data,       32'h0);
      chk("ar.ready", 32'(src_ready), 32'hF);
      m_reset();
      @(posedge CLK);
      #2 RST = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("ar.idle%0d", i), 32'(cdb_valid), 32'h0);
      end
      drive(0, 4'b0100, 16'h0700, {32'h0, 32'h77, 64'h0});
      cyc(); chk_model("ar.push");
      drive(0, 4'b0000, 16'h0, 128'h0);
      cyc(); chk_model("ar.bcast");
      chk("ar.first_tag", 32'(cdb_tag), 32'h7);

      // Random traffic, including INVALID_TAG sources and occasional flush.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 19) == 0), 4'($urandom),
               16'($urandom),
               {$urandom, $urandom, $urandom, $urandom});
         cyc();
         chk_model($sformatf("rnd%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_SRC, default 4, meaning the number of functional-unit result sources.
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the RS tag width.
REQ-003 The block SHALL have parameter INVALID_TAG, default all-ones of TAG_W, meaning the tag driven when no broadcast is active.
REQ-004 The block SHALL have parameter DEPTH, fixed at 2, meaning result buffer entries per source.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-006 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous discard of all buffered and in-flight results.
REQ-008 The block SHALL have port src_valid, input, NUM_SRC bits: per-source result-present flag.
REQ-009 The block SHALL have port src_ready, output, NUM_SRC bits: per-source buffer-can-accept flag.
REQ-010 The block SHALL have port src_tag, input, NUM_SRC*TAG_W bits: per-source RS tag, with source i in slice [i*TAG_W +: TAG_W].
REQ-011 The block SHALL have port src_data, input, NUM_SRC*32 bits: per-source result, with source i in slice [i*32 +: 32].
REQ-012 The block SHALL have port cdb_valid, output, 1 bit: a broadcast is on the CDB this cycle.
REQ-013 The block SHALL have port cdb_tag, output, TAG_W bits: the broadcast tag.
REQ-014 The block SHALL have port cdb_data, output, 32 bits: the broadcast value.

Function
REQ-015 Each source SHALL own a DEPTH-entry FIFO with a 2-bit count; src_ready[i] SHALL equal (count_i < DEPTH) and be computed only from registered state.
REQ-016 A push into FIFO i SHALL occur on a rising edge where src_valid[i] && src_ready[i] && !flush.
REQ-017 src_valid[i] with src_ready[i] low SHALL be ignored: no write, no error; the source holds its result.
REQ-018 Each cycle, the arbiter SHALL pick at most one non-empty FIFO, scanning indices rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
REQ-019 On a grant to source g, the head of FIFO g SHALL be popped and registered onto cdb_valid=1, cdb_tag, and cdb_data at the same edge, and rr_ptr SHALL become (g+1) mod NUM_SRC.
REQ-020 When no FIFO is non-empty, the next edge SHALL drive cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0, and rr_ptr SHALL be unchanged.
REQ-021 Each broadcast SHALL last exactly one cycle; the CDB has no backpressure.
REQ-022 cdb_tag SHALL equal INVALID_TAG whenever cdb_valid=0, because consumers match on tag alone.
REQ-023 Latency: a result pushed into an empty FIFO at edge k, if granted, SHALL be visible on the CDB after edge k+1 (minimum one cycle); there is no combinational path from src inputs to cdb outputs.
REQ-024 A simultaneous push and pop on the same FIFO SHALL leave count unchanged and preserve FIFO order.
REQ-025 Each FIFO SHALL wrap its read and write pointers modulo DEPTH.
REQ-026 Results from one source SHALL be broadcast in the order they were accepted.
REQ-027 A source with a pending result SHALL be granted within NUM_SRC cycles.
REQ-028 flush SHALL take priority over push and grant: at that edge, all counts and pointers go to 0, cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0, and rr_ptr=0.
REQ-029 A src_tag equal to INVALID_TAG SHALL be accepted and broadcast with cdb_valid=1; filtering it is the source's responsibility.

Reset
REQ-030 While RST=1, asynchronously: all FIFO counts and pointers SHALL be 0, rr_ptr=0, cdb_valid=0, cdb_tag=INVALID_TAG, cdb_data=0, and src_ready=all ones.
REQ-031 An RST asserted mid-operation SHALL discard all buffered results without broadcasting them.
REQ-032 After RST deasserts, the first push SHALL be accepted at the next rising edge.

Verification
REQ-033 Single result: src_valid=4'b0010, tag1=5, data1=0xDEADBEEF for one cycle -> exactly one cycle later cdb_valid=1, tag=5, data=0xDEADBEEF, then cdb_valid=0, tag=0xF.
REQ-034 Contention: all four sources push at once (tags 1-4, rr_ptr=0) -> broadcasts on four consecutive cycles with tags 1,2,3,4, and rr_ptr ends at 0.
REQ-035 Backpressure: source 0 pushes 3 results while sources 1-3 keep source 0 losing arbitration -> src_ready[0]=0 after 2 are accepted; the third is held and then accepted; all three are broadcast in order.
REQ-036 Fairness: sources 0 and 3 push continuously -> grants alternate 0,3,0,3 with no source starved.
REQ-037 Flush: both FIFOs full and cdb_valid=1, then flush=1 for one cycle -> next cycle cdb_valid=0 and src_ready=4'b1111, and no stale tag ever appears afterwards.
REQ-038 Async reset: RST asserted between clock edges with results pending -> outputs go to reset values immediately, and no pending tag is broadcast after release.
